// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared decoded-control types and encodings
//
// Purpose: opcode constants, result/forward select encodings and the packed
// per-instruction control bundle shared by the decoder and ctrl_pipe_hazard.
// Ports: none (package).
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_src_pc;
  } ctrl_bundle_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - single-operand EX forwarding select
//
// Purpose: picks the source of one EX operand from MEM / WB / register file.
// Ports:
//   src                               EX source register index
//   mem_valid, mem_reg_write, mem_rd  MEM stage producer
//   wb_valid, wb_reg_write, wb_rd     WB stage producer
//   sel                               2-bit select (fwd_sel_e encoding)
module fwd_sel
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);

  // MEM holds the younger result, so it wins over WB; x0 never forwards.
  always_comb begin
    sel = FWD_RF;
    if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - EX/MEM/WB control pipeline with hazard and forwarding control
//
// Purpose: carries the decoded control bundle from ID through EX, MEM and WB,
// detects load-use and redirect hazards, drives stall/flush/bubble controls,
// EX forwarding selects and saturating stall/flush event counters.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_*                           decoded ID bundle and register indices
//   ex_branch_taken                EX comparator result
//   mem_wait                       data memory not ready, freezes pipeline
//   ex_*, mem_*, wb_*              stage controls, zero when stage invalid
//   pc_en, if_id_en, if_id_flush   front-end enables / flush
//   fwd_a, fwd_b                   EX operand forwarding selects
//   stall_cnt, flush_cnt           saturating event counters
module ctrl_pipe_hazard
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_alu_src,
  input  logic                  id_alu_src_pc,
  input  logic                  id_mem_write,
  input  logic                  id_mem_read,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [1:0]            id_result_src,
  input  logic [1:0]            id_alu_op,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic                  ex_alu_src,
  output logic                  ex_alu_src_pc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_alu_op,
  output logic                  mem_mem_write,
  output logic                  mem_mem_read,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_result_src,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_bundle_t id_ctrl;
  ctrl_bundle_t ex_ctrl;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;

  logic                  mem_valid, mem_reg_write;
  logic [1:0]            mem_result_src;
  logic                  mem_mem_write_q, mem_mem_read_q;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic                  wb_valid, wb_reg_write_q;
  logic [1:0]            wb_result_src_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic load_use, redirect, ex_bubble;

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.result_src = id_result_src;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.branch     = id_branch;
    id_ctrl.jump       = id_jump;
    id_ctrl.alu_op     = id_alu_op;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.alu_src_pc = id_alu_src_pc;
  end

  // Both sources are compared even if the ID instruction does not read rs2.
  assign load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;
  assign redirect = ex_valid && ((ex_ctrl.branch && ex_branch_taken) || ex_ctrl.jump);
  assign ex_bubble = redirect || load_use;

  // Front-end controls; mem_wait defers any pending redirect/stall.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    if (mem_wait) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (redirect) begin
      if_id_flush = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_ctrl         <= '0;
      ex_rd           <= '0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      mem_valid       <= 1'b0;
      mem_reg_write   <= 1'b0;
      mem_result_src  <= 2'b00;
      mem_mem_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_rd          <= '0;
      wb_valid        <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= 2'b00;
      wb_rd_q         <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else if (!mem_wait) begin
      // Fields always load; a bubble only clears valid, which gates outputs.
      ex_valid        <= id_valid && !ex_bubble;
      ex_ctrl         <= id_ctrl;
      ex_rd           <= id_rd;
      ex_rs1          <= id_rs1;
      ex_rs2          <= id_rs2;
      mem_valid       <= ex_valid;
      mem_reg_write   <= ex_ctrl.reg_write;
      mem_result_src  <= ex_ctrl.result_src;
      mem_mem_write_q <= ex_ctrl.mem_write;
      mem_mem_read_q  <= ex_ctrl.mem_read;
      mem_rd          <= ex_rd;
      wb_valid        <= mem_valid;
      wb_reg_write_q  <= mem_reg_write;
      wb_result_src_q <= mem_result_src;
      wb_rd_q         <= mem_rd;
      if (redirect) begin
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (load_use) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  assign ex_alu_src    = ex_valid & ex_ctrl.alu_src;
  assign ex_alu_src_pc = ex_valid & ex_ctrl.alu_src_pc;
  assign ex_branch     = ex_valid & ex_ctrl.branch;
  assign ex_jump       = ex_valid & ex_ctrl.jump;
  assign ex_alu_op     = ex_valid ? ex_ctrl.alu_op : 2'b00;
  assign mem_mem_write = mem_valid & mem_mem_write_q;
  assign mem_mem_read  = mem_valid & mem_mem_read_q;
  assign wb_reg_write  = wb_valid & wb_reg_write_q;
  assign wb_result_src = wb_valid ? wb_result_src_q : 2'b00;
  assign wb_rd         = wb_valid ? wb_rd_q : '0;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src           (ex_rs1),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write_q),
    .wb_rd         (wb_rd_q),
    .sel           (fwd_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src           (ex_rs2),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write_q),
    .wb_rd         (wb_rd_q),
    .sel           (fwd_b)
  );

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - directed self-checking bench for ctrl_pipe_hazard
module tb_ctrl_pipe_hazard;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_reg_write, id_alu_src, id_alu_src_pc;
  logic          id_mem_write, id_mem_read, id_branch, id_jump;
  logic [1:0]    id_result_src, id_alu_op;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_branch_taken, mem_wait;
  logic          ex_alu_src, ex_alu_src_pc, ex_branch, ex_jump;
  logic [1:0]    ex_alu_op;
  logic          mem_mem_write, mem_mem_read;
  logic          wb_reg_write;
  logic [1:0]    wb_result_src;
  logic [RW-1:0] wb_rd;
  logic          pc_en, if_id_en, if_id_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
    .id_alu_src_pc(id_alu_src_pc), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
    .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .ex_alu_src(ex_alu_src), .ex_alu_src_pc(ex_alu_src_pc), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src), .wb_rd(wb_rd),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rw, input logic [1:0] rs,
                        input logic mw, input logic mr, input logic br, input logic jp,
                        input logic asrc, input logic [1:0] aop,
                        input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                        input logic [RW-1:0] rd);
    id_valid = v;  id_reg_write = rw; id_result_src = rs; id_mem_write = mw;
    id_mem_read = mr; id_branch = br; id_jump = jp; id_alu_src = asrc;
    id_alu_src_pc = 1'b0; id_alu_op = aop; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic id_nop();
    set_id(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic id_add(input logic [RW-1:0] rd, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    set_id(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, r1, r2, rd);
  endtask

  task automatic id_lw(input logic [RW-1:0] rd, input logic [RW-1:0] r1);
    set_id(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, r1, 5'd0, rd);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_wait = 1'b0;
    id_add(5'd5, 5'd1, 5'd2);

    // Reset state with a live ID bundle present.
    tick(); tick();
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_ex_alu_op", 32'(ex_alu_op), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_if_id_en", 32'(if_id_en), 32'd1);
    chk("rst_flush", 32'(if_id_flush), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    rst_n = 1'b1;

    // ADD rd=5 walks through EX, MEM, WB.
    tick();
    chk("add_ex_alu_op", 32'(ex_alu_op), 32'd2);
    id_nop();
    tick();
    chk("add_ex_empty", 32'(ex_alu_op), 32'd0);
    tick();
    chk("add_wb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("add_wb_rd", 32'(wb_rd), 32'd5);
    chk("add_wb_result_src", 32'(wb_result_src), 32'd0);
    tick(); tick();

    // LW rd=3 then ADD rs1=3: one stall then WB forwarding.
    id_lw(5'd3, 5'd1);
    tick();
    id_add(5'd6, 5'd3, 5'd7);
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_flush", 32'(if_id_flush), 32'd0);
    tick();
    chk("lu_ex_bubble", 32'({ex_alu_op, ex_alu_src}), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_mem_read", 32'(mem_mem_read), 32'd1);
    chk("lu_released", 32'(pc_en), 32'd1);
    tick();
    chk("lu_fwd_a", 32'(fwd_a), 32'd1);
    chk("lu_fwd_b", 32'(fwd_b), 32'd0);
    chk("lu_wb_src", 32'(wb_result_src), 32'd1);
    chk("lu_wb_rd", 32'(wb_rd), 32'd3);
    id_nop();
    tick(); tick(); tick();

    // Back-to-back dependency: forward from MEM.
    id_add(5'd4, 5'd1, 5'd2);
    tick();
    id_add(5'd8, 5'd4, 5'd4);
    tick();
    chk("fwd_mem_a", 32'(fwd_a), 32'd2);
    chk("fwd_mem_b", 32'(fwd_b), 32'd2);
    id_nop();
    tick(); tick(); tick();

    // One intervening NOP: forward from WB.
    id_add(5'd4, 5'd1, 5'd2);
    tick();
    id_nop();
    tick();
    id_add(5'd8, 5'd4, 5'd4);
    tick();
    chk("fwd_wb_a", 32'(fwd_a), 32'd1);
    chk("fwd_wb_b", 32'(fwd_b), 32'd1);
    id_nop();
    tick(); tick(); tick();

    // x0 destination never forwards.
    id_add(5'd0, 5'd1, 5'd2);
    tick();
    id_add(5'd8, 5'd0, 5'd0);
    tick();
    chk("fwd_x0", 32'({fwd_a, fwd_b}), 32'd0);
    id_nop();
    tick(); tick(); tick();

    // Same rd in MEM and WB: MEM wins.
    id_add(5'd9, 5'd1, 5'd2);
    tick();
    id_add(5'd9, 5'd1, 5'd2);
    tick();
    id_add(5'd10, 5'd9, 5'd1);
    tick();
    chk("fwd_prio_a", 32'(fwd_a), 32'd2);
    chk("fwd_prio_b", 32'(fwd_b), 32'd0);
    id_nop();
    tick(); tick(); tick();

    // Taken branch in EX that also looks like a load to the hazard unit.
    set_id(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 5'd3);
    tick();
    id_add(5'd6, 5'd3, 5'd0);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", 32'(if_id_flush), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    chk("br_if_id_en", 32'(if_id_en), 32'd1);
    tick();
    ex_branch_taken = 1'b0;
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("br_ex_bubble", 32'(ex_branch), 32'd0);
    id_nop();
    tick(); tick(); tick();

    // JAL in EX frozen by mem_wait for 4 cycles.
    set_id(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd1);
    tick();
    id_nop();
    mem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_flush", 32'(if_id_flush), 32'd0);
      chk("mw_pc_en", 32'({pc_en, if_id_en}), 32'd0);
      chk("mw_ex_jump", 32'(ex_jump), 32'd1);
      chk("mw_flush_cnt", 32'(flush_cnt), 32'd1);
      tick();
    end
    mem_wait = 1'b0;
    #1;
    chk("mw_release_flush", 32'(if_id_flush), 32'd1);
    chk("mw_release_pc_en", 32'(pc_en), 32'd1);
    tick();
    chk("mw_flush_cnt_inc", 32'(flush_cnt), 32'd2);
    chk("mw_ex_cleared", 32'(ex_jump), 32'd0);
    tick();
    chk("mw_wb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("mw_wb_rd", 32'(wb_rd), 32'd1);
    chk("mw_wb_src", 32'(wb_result_src), 32'd2);
    tick();

    // 2^CW+5 further load-use stalls: counter must stick at all-ones.
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      id_lw(5'd3, 5'd1);
      tick();
      id_add(5'd6, 5'd3, 5'd0);
      tick();
    end
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
    chk("sat_flush_cnt", 32'(flush_cnt), 32'd2);

    // Asynchronous reset mid-run, between clock edges.
    id_lw(5'd3, 5'd1);
    tick();
    chk("pre_rst_ex_alu_src", 32'(ex_alu_src), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("async_rst_ex_alu_src", 32'(ex_alu_src), 32'd0);
    chk("async_rst_wb", 32'({wb_reg_write, wb_rd}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
